// File: rtl/sum_window_packer_if.sv
// Handshake bundle for sum_window_packer: sample stream in, packed 16-bit
// window totals out as two bytes (low then high).
interface sum_window_packer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] count;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, count
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, count
  );
endinterface

// File: rtl/sum_window_packer.sv
// Sums WINDOW 8-bit samples into a 16-bit total and emits it as two bytes,
// low byte first; the next window keeps accumulating while a total drains.
module sum_window_packer #(
  parameter int WINDOW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_window_packer_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;

  localparam logic [7:0] LAST_CNT = 8'(WINDOW - 1);

  logic [1:0]  state, state_nxt;
  logic [15:0] acc, total;
  logic [7:0]  cnt;
  logic        in_fire, out_fire, at_last, win_final;
  logic        ready, vld;

  assign at_last   = (cnt == LAST_CNT);
  assign in_fire   = bus.in_valid && ready;
  assign out_fire  = vld && bus.out_ready;
  assign win_final = in_fire && at_last;

  // A new total may only land when the hold register is free at the next
  // edge: idle, or the high byte leaving this very cycle.
  always_comb begin
    ready = 1'b1;
    if (at_last && (state == LO || (state == HI && !bus.out_ready)))
      ready = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_final) state_nxt = LO;
      LO:      if (out_fire)  state_nxt = HI;
      HI: begin
        if (win_final)     state_nxt = LO;
        else if (out_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 16'd0;
      cnt   <= 8'd0;
      total <= 16'd0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        if (at_last) begin
          total <= acc + {8'd0, bus.in_data};
          acc   <= 16'd0;
          cnt   <= 8'd0;
        end else begin
          acc   <= acc + {8'd0, bus.in_data};
          cnt   <= cnt + 8'd1;
        end
      end
    end
  end

  assign vld = (state == LO) || (state == HI);

  always_comb begin
    bus.out_data = 8'd0;
    if (state == LO)      bus.out_data = total[7:0];
    else if (state == HI) bus.out_data = total[15:8];
  end

  assign bus.out_valid = vld;
  assign bus.out_last  = (state == HI);
  assign bus.in_ready  = ready;
  assign bus.count     = cnt;

endmodule

// File: doc/sum_window_packer.md
SUM_WINDOW_PACKER -- requirements
Module: sum_window_packer

Interface
REQ-001 SHALL have parameter WINDOW, default 4, meaning the number of 8-bit samples summed per output word; legal range 2..255.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  8  unsigned sample, the 8-bit sum stream from the adder stage.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_data  output  8  current byte of the packed window total.
REQ-008 SHALL have port out_valid  output  1  out_data is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL have port out_last  output  1  high while the high byte is presented.
REQ-011 SHALL have port count  output  8  number of samples accumulated in the current window.

Function
REQ-012 SHALL define an input transfer as in_valid && in_ready, and an output transfer as out_valid && out_ready, both sampled at the rising edge of clk.
REQ-013 SHALL keep a 16-bit accumulator acc and an 8-bit counter cnt (count = cnt); each input transfer adds the zero-extended in_data to acc and increments cnt.
REQ-014 SHALL treat the input transfer made when cnt == WINDOW-1 as window-final: latch total = acc + in_data into a 16-bit hold register, clear acc and cnt to 0, and set the output state to LO.
REQ-015 SHALL never overflow the 16-bit total (255*255 < 2^16); no saturation or wrap logic is required.
REQ-016 SHALL implement an output FSM with states IDLE, LO and HI: IDLE -> LO on a window-final transfer; LO -> HI on an output transfer; HI -> IDLE on an output transfer, or HI -> LO if a window-final transfer occurs in the same cycle.
REQ-017 SHALL drive out_valid=1 in LO and HI and 0 in IDLE; out_data = total[7:0] with out_last=0 in LO; out_data = total[15:8] with out_last=1 in HI; out_data=0 in IDLE.
REQ-018 SHALL keep accumulating the next window while LO/HI is being sent (total is held separately from acc).
REQ-019 SHALL drive in_ready = 0 only when the FSM is in LO, or in HI without out_ready asserted, while cnt == WINDOW-1; in_ready = 1 otherwise (combinational from state, cnt and out_ready).
REQ-020 SHALL present the first output byte (out_valid=1, LO) in the cycle immediately after the window-final edge, for a latency of 1 cycle.
REQ-021 SHALL hold out_data, out_last and total stable while out_valid=1 and out_ready=0.
REQ-022 SHALL ignore in_data when in_valid=0, and ignore out_ready in IDLE.

Reset
REQ-023 SHALL, on any clk edge with rst=1, set the FSM to IDLE, acc=0, cnt=0 and total=0, overriding any same-cycle transfer.
REQ-024 SHALL give the reset values out_valid=0, out_data=0, out_last=0, count=0 and in_ready=1 in the cycle after reset.
REQ-025 SHALL discard a partially accumulated window and any untransmitted bytes when reset is asserted mid-operation.

Verification (WINDOW=4)
REQ-026 SHALL cover: samples 10,20,30,40 on consecutive cycles, out_ready=1 -> out_data 0x64 (out_last=0), then 0x00 (out_last=1), then out_valid=0.
REQ-027 SHALL cover: four samples of 255 -> bytes 0xFC then 0x03, and count sequences 1,2,3,0.
REQ-028 SHALL cover: out_ready=0 after window 1 (total 100); stream 1,2,3,4 -> first three samples accepted, in_ready=0 on the 4th until both bytes drain; then bytes 0x0A, 0x00.
REQ-029 SHALL cover: rst pulsed after samples 5,6; then samples 1,1,1,1 -> output 0x04, 0x00 (no residue from before reset).
REQ-030 SHALL cover: rst asserted while in LO with out_ready=0 -> out_valid=0 and count=0 the next cycle.
REQ-031 SHALL cover: in_valid toggling every other cycle with samples 50,60,70,80 and back-to-back windows where window 2 finishes on the HI transfer cycle -> bytes 0x04,0x01 then window-2 bytes with no idle cycle between them.
